// File: rtl/register_file_if.sv
// Register file bus: two enabled write ports and two combinational read ports.
// The datapath side uses master and the register file uses slave.
interface register_file_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   logic [1:0]            write_en;
   logic [ADDR_WIDTH-1:0] read_addr_0;
   logic [ADDR_WIDTH-1:0] read_addr_1;
   logic [ADDR_WIDTH-1:0] reg_write_addr_0;
   logic [ADDR_WIDTH-1:0] reg_write_addr_1;
   logic [DATA_WIDTH-1:0] data_in_0;
   logic [DATA_WIDTH-1:0] data_in_1;
   logic [DATA_WIDTH-1:0] read_data_0;
   logic [DATA_WIDTH-1:0] read_data_1;

   modport master (
      output write_en, read_addr_0, read_addr_1,
      output reg_write_addr_0, reg_write_addr_1, data_in_0, data_in_1,
      input  read_data_0, read_data_1
   );

   modport slave (
      input  write_en, read_addr_0, read_addr_1,
      input  reg_write_addr_0, reg_write_addr_1, data_in_0, data_in_1,
      output read_data_0, read_data_1
   );
endinterface

// File: rtl/register_file.sv
// 8 x 16-bit general-purpose register file: two async read ports, two
// independently enabled synchronous write ports, synchronous active-high reset.
module register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int NUM_REGS   = 8
) (
   input logic            clk,
   input logic            rst,
   register_file_if.slave rf
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // Port 1 is applied last so it wins when both ports hit the same address.
   always_comb begin
      regs_d = regs_q;
      if (rf.write_en[0]) regs_d[rf.reg_write_addr_0] = rf.data_in_0;
      if (rf.write_en[1]) regs_d[rf.reg_write_addr_1] = rf.data_in_1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // No write bypass: reads always reflect the stored state.
   assign rf.read_data_0 = regs_q[rf.read_addr_0];
   assign rf.read_data_1 = regs_q[rf.read_addr_1];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array model of the eight registers.
module tb_register_file;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [15:0] model [8];

   always #10 clk = ~clk;

   register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) rf_if ();

   register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf_if)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic r, input logic [1:0] we,
                        input logic [2:0] a0, input logic [15:0] d0,
                        input logic [2:0] a1, input logic [15:0] d1);
      rst                    = r;
      rf_if.write_en         = we;
      rf_if.reg_write_addr_0 = a0;
      rf_if.data_in_0        = d0;
      rf_if.reg_write_addr_1 = a1;
      rf_if.data_in_1        = d1;
   endtask

   // Model the effect of the coming edge from the currently driven inputs, then take it.
   task automatic clock_edge();
      if (rst) begin
         for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      end else begin
         if (rf_if.write_en[0]) model[rf_if.reg_write_addr_0] = rf_if.data_in_0;
         if (rf_if.write_en[1]) model[rf_if.reg_write_addr_1] = rf_if.data_in_1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [2:0] ra0, input logic [2:0] ra1);
      rf_if.read_addr_0 = ra0;
      rf_if.read_addr_1 = ra1;
      #1;
      chk({tag, "_rd0"}, rf_if.read_data_0, model[ra0]);
      chk({tag, "_rd1"}, rf_if.read_data_1, model[ra1]);
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] a;
         a = 3'(i);
         read_chk(tag, a, ~a);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
      drive(1'b1, 2'b11, 3'd1, 16'hFFFF, 3'd6, 16'hEEEE);
      rf_if.read_addr_0 = '0;
      rf_if.read_addr_1 = '0;
      #1;

      // reset held for several edges, even with writes enabled
      repeat (3) clock_edge();
      drive(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
      #1;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] a;
         a = 3'(i);
         rf_if.read_addr_0 = a;
         rf_if.read_addr_1 = a;
         #1;
         chk("reset_rd0", rf_if.read_data_0, 16'h0000);
         chk("reset_rd1", rf_if.read_data_1, 16'h0000);
      end

      // basic writes through port 0
      drive(1'b0, 2'b01, 3'd2, 16'h1234, 3'd0, 16'h0);
      clock_edge();
      drive(1'b0, 2'b01, 3'd5, 16'h5678, 3'd0, 16'h0);
      clock_edge();
      drive(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
      rf_if.read_addr_0 = 3'd2;
      rf_if.read_addr_1 = 3'd5;
      #1;
      chk("wr_r2", rf_if.read_data_0, 16'h1234);
      chk("wr_r5", rf_if.read_data_1, 16'h5678);

      // read during write: old value until the edge
      drive(1'b0, 2'b01, 3'd2, 16'h2345, 3'd0, 16'h0);
      rf_if.read_addr_0 = 3'd2;
      #1;
      chk("nobypass_pre", rf_if.read_data_0, 16'h1234);
      clock_edge();
      chk("nobypass_post", rf_if.read_data_0, 16'h2345);

      // dual write, then collision
      drive(1'b0, 2'b11, 3'd2, 16'h2345, 3'd3, 16'h1234);
      clock_edge();
      rf_if.read_addr_0 = 3'd3;
      rf_if.read_addr_1 = 3'd2;
      #1;
      chk("dual_r3", rf_if.read_data_0, 16'h1234);
      chk("dual_r2", rf_if.read_data_1, 16'h2345);
      drive(1'b0, 2'b11, 3'd4, 16'hAAAA, 3'd4, 16'h5555);
      clock_edge();
      rf_if.read_addr_0 = 3'd4;
      #1;
      chk("collide_r4", rf_if.read_data_0, 16'h5555);

      // disabled port 1 has no effect
      drive(1'b0, 2'b01, 3'd7, 16'h0F0F, 3'd3, 16'h1010);
      clock_edge();
      rf_if.read_addr_0 = 3'd3;
      rf_if.read_addr_1 = 3'd7;
      #1;
      chk("p1_disabled_r3", rf_if.read_data_0, 16'h1234);
      chk("p0_enabled_r7", rf_if.read_data_1, 16'h0F0F);

      // register 0 is writable
      drive(1'b0, 2'b10, 3'd0, 16'h0, 3'd0, 16'hBEEF);
      clock_edge();
      read_chk("r0_writable", 3'd0, 3'd0);
      chk("r0_value", rf_if.read_data_0, 16'hBEEF);

      // single-edge reset overrides enabled writes
      drive(1'b1, 2'b11, 3'd1, 16'hDEAD, 3'd6, 16'hCAFE);
      clock_edge();
      drive(1'b0, 2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
      check_all("rst_override");
      rf_if.read_addr_0 = 3'd6;
      #1;
      chk("rst_override_r6", rf_if.read_data_0, 16'h0000);
      drive(1'b0, 2'b01, 3'd1, 16'h4321, 3'd0, 16'h0);
      clock_edge();
      rf_if.read_addr_0 = 3'd1;
      #1;
      chk("post_rst_write", rf_if.read_data_0, 16'h4321);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 29) == 0), 2'($urandom), 3'($urandom), 16'($urandom),
               3'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) rf_if.reg_write_addr_1 = rf_if.reg_write_addr_0;
         read_chk("rand_pre", 3'($urandom), 3'($urandom));
         clock_edge();
         read_chk("rand_post", rf_if.reg_write_addr_0, rf_if.reg_write_addr_1);
      end
      rst = 1'b0;
      rf_if.write_en = 2'b00;
      check_all("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
